// File: rtl/fetch_redirect_ctrl_pkg.sv
// Shared encodings for the fetch redirect controller: PC-mux selects,
// BTB commands, FSM state codes and redirect priorities.
package fetch_pkg;

  // PC mux select encodings
  localparam logic [1:0] PC_SEL_SEQ    = 2'b00;  // sequential / BTB prediction
  localparam logic [1:0] PC_SEL_BR     = 2'b01;  // branch target
  localparam logic [1:0] PC_SEL_JMP    = 2'b10;  // jump target
  localparam logic [1:0] PC_SEL_BR_FIX = 2'b11;  // br_pc + 4 correction

  // BTB write commands (one-hot)
  localparam logic [2:0] BTB_NONE          = 3'b000;
  localparam logic [2:0] BTB_INSERT        = 3'b001;
  localparam logic [2:0] BTB_UPD_TAKEN     = 3'b010;
  localparam logic [2:0] BTB_UPD_NOT_TAKEN = 3'b100;

  // FSM state codes
  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_HOLD      = 2'd1;
  localparam logic [1:0] ST_EXC_FLUSH = 2'd2;

  // Redirect priorities; a larger value wins
  localparam logic [1:0] PRI_NONE = 2'd0;
  localparam logic [1:0] PRI_JMP  = 2'd1;
  localparam logic [1:0] PRI_BR   = 2'd2;
  localparam logic [1:0] PRI_EXC  = 2'd3;

  // True for the PC selects that correct a branch misprediction
  function automatic logic is_branch_sel(input logic [1:0] sel);
    return (sel == PC_SEL_BR) || (sel == PC_SEL_BR_FIX);
  endfunction

endpackage

// File: rtl/fetch_redirect_ctrl_redirect_arbiter.sv
// Combinational redirect arbiter: classifies the resolved branch against
// its BTB prediction and picks the highest-priority redirect
// (exception > branch mispredict > jump). Branch and jump requests are
// masked while an exception flush is in progress.
module redirect_arbiter
  import fetch_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              suppress,
  input  logic              exc_req,
  input  logic [ADDR_W-1:0] exc_addr,
  input  logic              jmp_req,
  input  logic [ADDR_W-1:0] jmp_addr,
  input  logic              br_valid,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] br_target,
  input  logic [ADDR_W-1:0] br_pc,
  input  logic              pred_hit,
  input  logic              pred_taken,
  input  logic [ADDR_W-1:0] pred_target,
  output logic              req_valid,
  output logic [1:0]        req_pri,
  output logic [1:0]        req_sel,
  output logic [ADDR_W-1:0] req_addr,
  output logic [2:0]        req_btb,
  output logic              req_epc
);

  logic br_insert;
  logic br_upd_taken;
  logic br_upd_not_taken;

  // Branch classification against the prediction made at fetch
  always_comb begin
    br_insert        = br_valid && !pred_hit && br_taken;
    br_upd_taken     = br_valid && pred_hit && br_taken &&
                       (!pred_taken || (pred_target != br_target));
    br_upd_not_taken = br_valid && pred_hit && !br_taken && pred_taken;
  end

  // Priority selection of the winning redirect
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned, which would infer a latch.
    req_valid = 1'b0;
    req_pri   = PRI_NONE;
    req_sel   = PC_SEL_SEQ;
    req_addr  = '0;
    req_btb   = BTB_NONE;
    req_epc   = 1'b0;
    if (exc_req) begin
      req_valid = 1'b1;
      req_pri   = PRI_EXC;
      req_addr  = exc_addr;
      req_epc   = 1'b1;
    end else if (!suppress && (br_insert || br_upd_taken)) begin
      req_valid = 1'b1;
      req_pri   = PRI_BR;
      req_sel   = PC_SEL_BR;
      req_addr  = br_target;
      req_btb   = br_insert ? BTB_INSERT : BTB_UPD_TAKEN;
    end else if (!suppress && br_upd_not_taken) begin
      req_valid = 1'b1;
      req_pri   = PRI_BR;
      req_sel   = PC_SEL_BR_FIX;
      req_addr  = br_pc + ADDR_W'(4);
      req_btb   = BTB_UPD_NOT_TAKEN;
    end else if (!suppress && jmp_req) begin
      req_valid = 1'b1;
      req_pri   = PRI_JMP;
      req_sel   = PC_SEL_JMP;
      req_addr  = jmp_addr;
    end
  end

endmodule

// File: rtl/fetch_redirect_ctrl.sv
// Fetch redirect sequencing controller. Issues the winning redirect in the
// same cycle when fetch can accept it, otherwise holds it in a pending
// register until the stall clears, and drives IF/ID flushes including the
// multi-cycle flush after an exception.
// Optional feature: define FETCH_CTRL_PERF_EN to build the mispredict and
// redirect performance counters; otherwise both outputs are tied to 0.
module fetch_redirect_ctrl
  import fetch_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              exc_req,
  input  logic [ADDR_W-1:0] exc_addr,
  input  logic              jmp_req,
  input  logic [ADDR_W-1:0] jmp_addr,
  input  logic              br_valid,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] br_target,
  input  logic [ADDR_W-1:0] br_pc,
  input  logic              pred_hit,
  input  logic              pred_taken,
  input  logic [ADDR_W-1:0] pred_target,
  output logic              pc_write,
  output logic [1:0]        pc_sel,
  output logic              choose_epc,
  output logic [ADDR_W-1:0] redirect_addr,
  output logic              flush_if_id,
  output logic [2:0]        btb_write,
  output logic [31:0]       mispredict_cnt,
  output logic [31:0]       redirect_cnt
);

  localparam logic [2:0] FLUSH_LAST = 3'(FLUSH_CYCLES - 1);

  logic [1:0]        state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [1:0]        pend_pri_q;
  logic [1:0]        pend_sel_q;
  logic [ADDR_W-1:0] pend_addr_q;
  logic [2:0]        pend_btb_q;
  logic              pend_epc_q;

  logic              live_valid;
  logic [1:0]        live_pri;
  logic [1:0]        live_sel;
  logic [ADDR_W-1:0] live_addr;
  logic [2:0]        live_btb;
  logic              live_epc;

  logic              use_live;
  logic [1:0]        win_sel;
  logic [ADDR_W-1:0] win_addr;
  logic [2:0]        win_btb;
  logic              win_epc;

  logic              issue;
  logic              latch;
  logic              pc_write_c;
  logic              flush_c;

  redirect_arbiter #(.ADDR_W(ADDR_W)) u_arbiter (
    .suppress    (state_q == ST_EXC_FLUSH),
    .exc_req     (exc_req),
    .exc_addr    (exc_addr),
    .jmp_req     (jmp_req),
    .jmp_addr    (jmp_addr),
    .br_valid    (br_valid),
    .br_taken    (br_taken),
    .br_target   (br_target),
    .br_pc       (br_pc),
    .pred_hit    (pred_hit),
    .pred_taken  (pred_taken),
    .pred_target (pred_target),
    .req_valid   (live_valid),
    .req_pri     (live_pri),
    .req_sel     (live_sel),
    .req_addr    (live_addr),
    .req_btb     (live_btb),
    .req_epc     (live_epc)
  );

  // Winner: the live request, unless holding and it does not outrank pending
  always_comb begin
    use_live = (state_q != ST_HOLD) || (live_valid && (live_pri > pend_pri_q));
    win_sel  = use_live ? live_sel  : pend_sel_q;
    win_addr = use_live ? live_addr : pend_addr_q;
    win_btb  = use_live ? live_btb  : pend_btb_q;
    win_epc  = use_live ? live_epc  : pend_epc_q;
  end

  // Next-state, issue/latch decisions and flush counter
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    issue      = 1'b0;
    latch      = 1'b0;
    pc_write_c = 1'b0;
    flush_c    = 1'b0;
    case (state_q)
      ST_HOLD: begin
        if (stall) begin
          latch = use_live;
        end else begin
          issue      = 1'b1;
          pc_write_c = 1'b1;
          cnt_d      = '0;
          state_d    = win_epc ? ST_EXC_FLUSH : ST_IDLE;
        end
      end
      ST_EXC_FLUSH: begin
        pc_write_c = ~stall;
        flush_c    = 1'b1;
        if (live_valid) begin
          // Only an exception can get through the arbiter here
          if (stall) begin
            latch   = 1'b1;
            state_d = ST_HOLD;
          end else begin
            issue = 1'b1;
            cnt_d = '0;
          end
        end else if (cnt_q == FLUSH_LAST) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      default: begin
        pc_write_c = ~stall;
        if (live_valid) begin
          if (stall) begin
            latch   = 1'b1;
            state_d = ST_HOLD;
          end else begin
            issue = 1'b1;
            if (win_epc) begin
              cnt_d   = '0;
              state_d = ST_EXC_FLUSH;
            end
          end
        end
      end
    endcase
  end

  // Output drive; everything is forced low while reset is held
  always_comb begin
    pc_write      = 1'b0;
    pc_sel        = PC_SEL_SEQ;
    choose_epc    = 1'b0;
    redirect_addr = '0;
    flush_if_id   = 1'b0;
    btb_write     = BTB_NONE;
    if (reset) begin
      pc_write    = pc_write_c;
      flush_if_id = flush_c;
      if (issue) begin
        pc_sel        = win_sel;
        choose_epc    = win_epc;
        redirect_addr = win_addr;
        flush_if_id   = 1'b1;
        btb_write     = win_btb;
      end
    end
  end

  // FSM state, flush counter and pending redirect register
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      pend_pri_q  <= PRI_NONE;
      pend_sel_q  <= PC_SEL_SEQ;
      pend_addr_q <= '0;
      pend_btb_q  <= BTB_NONE;
      pend_epc_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (latch) begin
        pend_pri_q  <= live_pri;
        pend_sel_q  <= live_sel;
        pend_addr_q <= live_addr;
        pend_btb_q  <= live_btb;
        pend_epc_q  <= live_epc;
      end else if (issue && (state_q == ST_HOLD)) begin
        pend_pri_q <= PRI_NONE;
      end
    end
  end

`ifdef FETCH_CTRL_PERF_EN
  logic [31:0] mispredict_cnt_q;
  logic [31:0] redirect_cnt_q;

  // Performance counters: every issued redirect, and branch corrections
  always_ff @(posedge clk) begin
    if (!reset) begin
      mispredict_cnt_q <= '0;
      redirect_cnt_q   <= '0;
    end else if (issue) begin
      redirect_cnt_q <= redirect_cnt_q + 32'd1;
      if (is_branch_sel(win_sel)) begin
        mispredict_cnt_q <= mispredict_cnt_q + 32'd1;
      end
    end
  end

  assign mispredict_cnt = mispredict_cnt_q;
  assign redirect_cnt   = redirect_cnt_q;
`else
  assign mispredict_cnt = 32'd0;
  assign redirect_cnt   = 32'd0;
`endif

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// Self-checking bench for fetch_redirect_ctrl: a table of single-cycle
// unstalled vectors plus hand-written multi-cycle sequences for HOLD,
// exception flush and reset corner cases.
module tb_fetch_redirect_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        exc_req;
  logic [31:0] exc_addr;
  logic        jmp_req;
  logic [31:0] jmp_addr;
  logic        br_valid;
  logic        br_taken;
  logic [31:0] br_target;
  logic [31:0] br_pc;
  logic        pred_hit;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        pc_write;
  logic [1:0]  pc_sel;
  logic        choose_epc;
  logic [31:0] redirect_addr;
  logic        flush_if_id;
  logic [2:0]  btb_write;
  logic [31:0] mispredict_cnt;
  logic [31:0] redirect_cnt;

  int tests  = 0;
  int failed = 0;

  fetch_redirect_ctrl #(.ADDR_W(32), .FLUSH_CYCLES(2)) dut (
    .clk            (clk),
    .reset          (reset),
    .stall          (stall),
    .exc_req        (exc_req),
    .exc_addr       (exc_addr),
    .jmp_req        (jmp_req),
    .jmp_addr       (jmp_addr),
    .br_valid       (br_valid),
    .br_taken       (br_taken),
    .br_target      (br_target),
    .br_pc          (br_pc),
    .pred_hit       (pred_hit),
    .pred_taken     (pred_taken),
    .pred_target    (pred_target),
    .pc_write       (pc_write),
    .pc_sel         (pc_sel),
    .choose_epc     (choose_epc),
    .redirect_addr  (redirect_addr),
    .flush_if_id    (flush_if_id),
    .btb_write      (btb_write),
    .mispredict_cnt (mispredict_cnt),
    .redirect_cnt   (redirect_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        stall;
    logic        jmp_req;
    logic [31:0] jmp_addr;
    logic        br_valid;
    logic        br_taken;
    logic [31:0] br_target;
    logic [31:0] br_pc;
    logic        pred_hit;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        e_pc_write;
    logic [1:0]  e_pc_sel;
    logic [31:0] e_addr;
    logic        e_flush;
    logic [2:0]  e_btb;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    stall = 0; exc_req = 0; exc_addr = 0; jmp_req = 0; jmp_addr = 0;
    br_valid = 0; br_taken = 0; br_target = 0; br_pc = 0;
    pred_hit = 0; pred_taken = 0; pred_target = 0;
  endtask

  // Advance to just after the next rising edge
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Compare the full output set in one go
  task automatic check_out(input string tag, input logic pw, input logic [1:0] sel,
                           input logic epc, input logic [31:0] addr, input logic fl,
                           input logic [2:0] btb);
    #2;
    check({tag, ".pc_write"},      64'(pc_write),      64'(pw));
    check({tag, ".pc_sel"},        64'(pc_sel),        64'(sel));
    check({tag, ".choose_epc"},    64'(choose_epc),    64'(epc));
    check({tag, ".redirect_addr"}, 64'(redirect_addr), 64'(addr));
    check({tag, ".flush_if_id"},   64'(flush_if_id),   64'(fl));
    check({tag, ".btb_write"},     64'(btb_write),     64'(btb));
  endtask

  function automatic vec_t mkv(input logic st, input logic jr, input logic [31:0] ja,
                               input logic bv, input logic bt, input logic [31:0] btg,
                               input logic [31:0] bpc, input logic ph, input logic pt,
                               input logic [31:0] ptg, input logic pw, input logic [1:0] sel,
                               input logic [31:0] addr, input logic fl, input logic [2:0] btb);
    vec_t v;
    v.stall = st; v.jmp_req = jr; v.jmp_addr = ja; v.br_valid = bv; v.br_taken = bt;
    v.br_target = btg; v.br_pc = bpc; v.pred_hit = ph; v.pred_taken = pt;
    v.pred_target = ptg; v.e_pc_write = pw; v.e_pc_sel = sel; v.e_addr = addr;
    v.e_flush = fl; v.e_btb = btb;
    return v;
  endfunction

  initial begin
    //                st jr jaddr   bv bt btarget       br_pc         ph pt ptarget   | pw sel   addr          fl btb
    vecs[0]  = mkv(0, 0, 32'h0,   1, 1, 32'h40,       32'h30,       0, 0, 32'h0,     1, 2'b01, 32'h40,       1, 3'b001);
    vecs[1]  = mkv(0, 0, 32'h0,   1, 0, 32'h150,      32'h100,      1, 1, 32'h150,   1, 2'b11, 32'h104,      1, 3'b100);
    vecs[2]  = mkv(0, 0, 32'h0,   1, 0, 32'h80,       32'h60,       0, 0, 32'h0,     1, 2'b00, 32'h0,        0, 3'b000);
    vecs[3]  = mkv(0, 0, 32'h0,   1, 1, 32'h300,      32'h2F0,      1, 1, 32'h300,   1, 2'b00, 32'h0,        0, 3'b000);
    vecs[4]  = mkv(0, 0, 32'h0,   1, 1, 32'h300,      32'h2F0,      1, 1, 32'h304,   1, 2'b01, 32'h300,      1, 3'b010);
    vecs[5]  = mkv(0, 0, 32'h0,   1, 1, 32'h500,      32'h4F0,      1, 0, 32'h500,   1, 2'b01, 32'h500,      1, 3'b010);
    vecs[6]  = mkv(0, 0, 32'h0,   1, 0, 32'h500,      32'h4F0,      1, 0, 32'h0,     1, 2'b00, 32'h0,        0, 3'b000);
    vecs[7]  = mkv(0, 1, 32'h200, 0, 0, 32'h0,        32'h0,        0, 0, 32'h0,     1, 2'b10, 32'h200,      1, 3'b000);
    vecs[8]  = mkv(0, 1, 32'h200, 1, 1, 32'h40,       32'h30,       0, 0, 32'h0,     1, 2'b01, 32'h40,       1, 3'b001);
    vecs[9]  = mkv(0, 1, 32'h200, 1, 1, 32'h300,      32'h2F0,      1, 1, 32'h300,   1, 2'b10, 32'h200,      1, 3'b000);
    vecs[10] = mkv(0, 0, 32'h0,   1, 0, 32'h10,       32'hFFFFFFFC, 1, 1, 32'h10,    1, 2'b11, 32'h0,        1, 3'b100);
    vecs[11] = mkv(1, 0, 32'h0,   0, 0, 32'h0,        32'h0,        0, 0, 32'h0,     0, 2'b00, 32'h0,        0, 3'b000);

    // Reset: outputs held low even with a request and no stall present
    reset = 0;
    clear_inputs();
    next_cycle();
    next_cycle();
    jmp_req = 1; jmp_addr = 32'h200;
    check_out("reset", 0, 2'b00, 0, 32'h0, 0, 3'b000);
    check("reset.mispredict_cnt", 64'(mispredict_cnt), 64'd0);
    check("reset.redirect_cnt",   64'(redirect_cnt),   64'd0);
    clear_inputs();
    reset = 1;
    next_cycle();
    check_out("idle", 1, 2'b00, 0, 32'h0, 0, 3'b000);

    // Table of single-cycle vectors, each from IDLE
    for (int i = 0; i < 12; i++) begin
      next_cycle();
      clear_inputs();
      stall = vecs[i].stall; jmp_req = vecs[i].jmp_req; jmp_addr = vecs[i].jmp_addr;
      br_valid = vecs[i].br_valid; br_taken = vecs[i].br_taken;
      br_target = vecs[i].br_target; br_pc = vecs[i].br_pc;
      pred_hit = vecs[i].pred_hit; pred_taken = vecs[i].pred_taken;
      pred_target = vecs[i].pred_target;
      check_out($sformatf("v%0d", i), vecs[i].e_pc_write, vecs[i].e_pc_sel, 1'b0,
                vecs[i].e_addr, vecs[i].e_flush, vecs[i].e_btb);
      next_cycle();
      clear_inputs();
      repeat (3) next_cycle();
    end

    // Stalled jump held for 3 cycles, issued when stall drops
    next_cycle();
    clear_inputs();
    stall = 1; jmp_req = 1; jmp_addr = 32'h200;
    check_out("hold_j0", 0, 2'b00, 0, 32'h0, 0, 3'b000);
    next_cycle(); clear_inputs(); stall = 1;
    check_out("hold_j1", 0, 2'b00, 0, 32'h0, 0, 3'b000);
    next_cycle(); stall = 1;
    check_out("hold_j2", 0, 2'b00, 0, 32'h0, 0, 3'b000);
    next_cycle(); stall = 0;
    check_out("hold_jrel", 1, 2'b10, 0, 32'h200, 1, 3'b000);
    next_cycle();
    check_out("hold_jafter", 1, 2'b00, 0, 32'h0, 0, 3'b000);

    // Pending jump overwritten by an exception, then the exception flush
    next_cycle(); clear_inputs();
    stall = 1; jmp_req = 1; jmp_addr = 32'h200;
    check_out("ovr_j", 0, 2'b00, 0, 32'h0, 0, 3'b000);
    next_cycle(); clear_inputs();
    stall = 1; exc_req = 1; exc_addr = 32'h80;
    check_out("ovr_e", 0, 2'b00, 0, 32'h0, 0, 3'b000);
    next_cycle(); clear_inputs();
    check_out("ovr_rel", 1, 2'b00, 1, 32'h80, 1, 3'b000);
    for (int k = 0; k < 2; k++) begin
      next_cycle(); clear_inputs();
      br_valid = 1; br_taken = 1; br_target = 32'h40;
      check_out($sformatf("ovr_fl%0d", k), 1, 2'b00, 0, 32'h0, 1, 3'b000);
    end
    next_cycle(); clear_inputs();
    check_out("ovr_done", 1, 2'b00, 0, 32'h0, 0, 3'b000);

    // Pending jump outranked by a branch; a later jump is ignored
    next_cycle(); clear_inputs();
    stall = 1; jmp_req = 1; jmp_addr = 32'h200;
    next_cycle(); clear_inputs();
    stall = 1; br_valid = 1; br_taken = 1; br_target = 32'h40;
    next_cycle(); clear_inputs();
    stall = 1; jmp_req = 1; jmp_addr = 32'h999;
    check_out("pri_j2", 0, 2'b00, 0, 32'h0, 0, 3'b000);
    next_cycle(); clear_inputs();
    check_out("pri_rel", 1, 2'b01, 0, 32'h40, 1, 3'b001);

    // Simultaneous exception, jump and mispredict: only the exception
    next_cycle(); clear_inputs();
    exc_req = 1; exc_addr = 32'h1000; jmp_req = 1; jmp_addr = 32'h200;
    br_valid = 1; br_taken = 1; br_target = 32'h40;
    check_out("sim", 1, 2'b00, 1, 32'h1000, 1, 3'b000);

    // A new exception mid-flush issues at once and restarts the count
    next_cycle(); clear_inputs();
    exc_req = 1; exc_addr = 32'h90;
    check_out("rst_cnt", 1, 2'b00, 1, 32'h90, 1, 3'b000);
    next_cycle(); clear_inputs();
    check_out("rst_cnt_f0", 1, 2'b00, 0, 32'h0, 1, 3'b000);
    next_cycle();
    check_out("rst_cnt_f1", 1, 2'b00, 0, 32'h0, 1, 3'b000);
    next_cycle();
    check_out("rst_cnt_end", 1, 2'b00, 0, 32'h0, 0, 3'b000);

    // Reset mid-flush discards everything
    next_cycle(); clear_inputs();
    exc_req = 1; exc_addr = 32'h80;
    check_out("mid_exc", 1, 2'b00, 1, 32'h80, 1, 3'b000);
    next_cycle(); clear_inputs();
    reset = 0;
    check_out("mid_rst", 0, 2'b00, 0, 32'h0, 0, 3'b000);
    next_cycle();
    reset = 1;
    check_out("post_rst", 1, 2'b00, 0, 32'h0, 0, 3'b000);
    check("post_rst.mispredict_cnt", 64'(mispredict_cnt), 64'd0);
    check("post_rst.redirect_cnt",   64'(redirect_cnt),   64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
